// File: rtl/mac8_ctrl_pkg.sv
// Shared types and widths for the MAC8 accumulator controller.
// The per-entry saturation flag exists only when MAC8_SAT_EN is defined.
package mac8_ctrl_pkg;

    localparam int MAC8_ACC_W         = 32;
    localparam int MAC8_TRANS_ID_BITS = 3;

    typedef enum logic {
        MAC8_INIT = 1'b0,
        MAC8_ACC  = 1'b1
    } mac8_op_e;

    typedef struct packed {
        logic [MAC8_TRANS_ID_BITS-1:0] trans_id;
        logic [MAC8_ACC_W-1:0]         value;
`ifdef MAC8_SAT_EN
        logic                          sat;
`endif
    } mac8_entry_t;

endpackage

// File: rtl/mac8_acc_ctrl_if.sv
// Issue / writeback / commit bundle of the MAC8 accumulator controller.
// sat_o is present only when MAC8_SAT_EN is defined.
interface mac8_acc_ctrl_if
    import mac8_ctrl_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = MAC8_TRANS_ID_BITS,
    parameter int ACC_W         = MAC8_ACC_W
);

    // An op transfers on a cycle where issue_valid_i & issue_ready_o are both
    // high and flush_i is low; the offer must hold its fields while valid is high.
    logic                     flush_i;
    logic                     issue_valid_i;
    logic                     issue_ready_o;
    mac8_op_e                 issue_op_i;
    logic [ACC_W-1:0]         issue_data_i;
    logic [TRANS_ID_BITS-1:0] issue_trans_id_i;
    logic                     result_valid_o;
    logic [ACC_W-1:0]         result_o;
    logic [TRANS_ID_BITS-1:0] result_trans_id_o;
    logic                     commit_valid_i;
    logic [TRANS_ID_BITS-1:0] commit_trans_id_i;
    logic                     commit_err_o;
    logic [ACC_W-1:0]         acc_arch_o;
    logic [$clog2(DEPTH):0]   pending_cnt_o;
`ifdef MAC8_SAT_EN
    logic                     sat_o;
`endif

    modport master (
        output flush_i, issue_valid_i, issue_op_i, issue_data_i, issue_trans_id_i,
        output commit_valid_i, commit_trans_id_i,
`ifdef MAC8_SAT_EN
        input  sat_o,
`endif
        input  issue_ready_o, result_valid_o, result_o, result_trans_id_o,
        input  commit_err_o, acc_arch_o, pending_cnt_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_op_i, issue_data_i, issue_trans_id_i,
        input  commit_valid_i, commit_trans_id_i,
`ifdef MAC8_SAT_EN
        output sat_o,
`endif
        output issue_ready_o, result_valid_o, result_o, result_trans_id_o,
        output commit_err_o, acc_arch_o, pending_cnt_o
    );

endinterface

// File: rtl/mac8_spec_fifo.sv
// In-order queue of issued-but-uncommitted MAC8 entries; pointers carry an
// extra wrap bit so full and empty are distinguishable. Clear wins over push/pop.
module mac8_spec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mac8_acc_ctrl.sv
// Speculation-safe MAC8 accumulator controller: speculative and architectural
// accumulators plus a pending-op queue. MAC8_SAT_EN selects saturating ACC adds.
module mac8_acc_ctrl
    import mac8_ctrl_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = MAC8_TRANS_ID_BITS,
    parameter int ACC_W         = MAC8_ACC_W
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    mac8_acc_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = $bits(mac8_entry_t);

    logic [ACC_W-1:0]         spec_q, spec_d;
    logic [ACC_W-1:0]         arch_q, arch_d;
    logic [ACC_W-1:0]         result_q, result_d;
    logic [TRANS_ID_BITS-1:0] result_id_q, result_id_d;
    logic                     result_valid_q, result_valid_d;
    logic                     commit_err_q, commit_err_d;
    logic                     alive_q, alive_d;
    logic [ACC_W-1:0]         sum, new_val;
    logic                     accept, commit_ok, full, empty;
    logic [CNT_W-1:0]         count;
    logic [ENT_W-1:0]         head_bits;
    mac8_entry_t              head, push_entry;
`ifdef MAC8_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic new_sat;
    logic sat_q, sat_d;
`endif

    assign accept    = bus.issue_valid_i & bus.issue_ready_o & ~bus.flush_i;
    assign head      = mac8_entry_t'(head_bits);
    assign commit_ok = bus.commit_valid_i & ~empty &
                       (head.trans_id == bus.commit_trans_id_i);

    // Value the offered op would produce on top of the current speculative state.
    always_comb begin
        sum     = spec_q + bus.issue_data_i;
        new_val = sum;
`ifdef MAC8_SAT_EN
        new_sat = 1'b0;
        if ((spec_q[ACC_W-1] == bus.issue_data_i[ACC_W-1]) &&
            (sum[ACC_W-1] != spec_q[ACC_W-1])) begin
            new_sat = 1'b1;
            new_val = spec_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        if (bus.issue_op_i == MAC8_INIT) begin
            new_val = bus.issue_data_i;
`ifdef MAC8_SAT_EN
            new_sat = 1'b0;
`endif
        end
        push_entry          = '0;
        push_entry.trans_id = bus.issue_trans_id_i;
        push_entry.value    = new_val;
`ifdef MAC8_SAT_EN
        push_entry.sat      = new_sat;
`endif
    end

    // Commit resolves before flush, so a flush restores the just-committed value.
    always_comb begin
        alive_d        = 1'b1;
        arch_d         = commit_ok ? head.value : arch_q;
        spec_d         = spec_q;
        if (bus.flush_i)  spec_d = arch_d;
        else if (accept)  spec_d = new_val;
        result_valid_d = accept;
        result_d       = accept ? new_val : result_q;
        result_id_d    = accept ? bus.issue_trans_id_i : result_id_q;
        commit_err_d   = bus.commit_valid_i & ~commit_ok;
`ifdef MAC8_SAT_EN
        sat_d          = sat_q | (commit_ok & head.sat);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_q         <= '0;
            arch_q         <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
            commit_err_q   <= 1'b0;
            alive_q        <= 1'b0;
`ifdef MAC8_SAT_EN
            sat_q          <= 1'b0;
`endif
        end else begin
            spec_q         <= spec_d;
            arch_q         <= arch_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_valid_q <= result_valid_d;
            commit_err_q   <= commit_err_d;
            alive_q        <= alive_d;
`ifdef MAC8_SAT_EN
            sat_q          <= sat_d;
`endif
        end
    end

    mac8_spec_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (commit_ok),
        .clear_i (bus.flush_i),
        .head_o  (head_bits),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // alive_q keeps ready low while reset is asserted.
    assign bus.issue_ready_o     = alive_q & ~full;
    assign bus.result_valid_o    = result_valid_q;
    assign bus.result_o          = result_q;
    assign bus.result_trans_id_o = result_id_q;
    assign bus.commit_err_o      = commit_err_q;
    assign bus.acc_arch_o        = arch_q;
    assign bus.pending_cnt_o     = count;
`ifdef MAC8_SAT_EN
    assign bus.sat_o             = sat_q;
`endif

endmodule

// File: tb/tb_mac8_acc_ctrl.sv
// Bench for mac8_acc_ctrl: directed vector table, async-reset sequence and a
// model-driven random phase; works with and without MAC8_SAT_EN.
module tb_mac8_acc_ctrl;
    import mac8_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    typedef struct {
        logic             iv;
        mac8_op_e         op;
        logic [31:0]      data;
        logic [2:0]       id;
        logic             cv;
        logic [2:0]       cid;
        logic             fl;
        logic             exp_acc;
        logic [31:0]      exp_res;
        logic [31:0]      exp_arch;
        logic             exp_err;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_rdy;
        logic             exp_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac8_acc_ctrl_if #(.DEPTH(DEPTH), .TRANS_ID_BITS(3), .ACC_W(32)) bus ();

    mac8_acc_ctrl #(.DEPTH(DEPTH), .TRANS_ID_BITS(3), .ACC_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [2:0]  exp_id_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        tbl_sat = 1'b0;
    logic [31:0] sat_res;

    logic [2:0]  m_id[$];
    logic [31:0] m_val[$];
    logic        m_satq[$];
    logic [31:0] m_spec, m_arch;
    logic        m_sat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input mac8_op_e op, input logic [31:0] data,
                                input logic [2:0] id, input logic cv, input logic [2:0] cid,
                                input logic fl, input logic exp_acc, input logic [31:0] exp_res,
                                input logic [31:0] exp_arch, input logic exp_err,
                                input int exp_cnt, input logic exp_rdy);
        vec_t v;
        v.iv = iv; v.op = op; v.data = data; v.id = id;
        v.cv = cv; v.cid = cid; v.fl = fl;
        v.exp_acc = exp_acc; v.exp_res = exp_res; v.exp_arch = exp_arch;
        v.exp_err = exp_err; v.exp_cnt = exp_cnt[CNT_W-1:0]; v.exp_rdy = exp_rdy;
        v.exp_sat = tbl_sat;
        return v;
    endfunction

    task automatic add(input logic iv, input mac8_op_e op, input logic [31:0] data,
                       input logic [2:0] id, input logic cv, input logic [2:0] cid,
                       input logic fl, input logic exp_acc, input logic [31:0] exp_res,
                       input logic [31:0] exp_arch, input logic exp_err,
                       input int exp_cnt, input logic exp_rdy);
        vecs.push_back(mk(iv, op, data, id, cv, cid, fl, exp_acc, exp_res,
                          exp_arch, exp_err, exp_cnt, exp_rdy));
    endtask

    task automatic drive_idle();
        bus.flush_i           = 1'b0;
        bus.issue_valid_i     = 1'b0;
        bus.issue_op_i        = MAC8_INIT;
        bus.issue_data_i      = '0;
        bus.issue_trans_id_i  = '0;
        bus.commit_valid_i    = 1'b0;
        bus.commit_trans_id_i = '0;
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        logic [2:0]  eid;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            eid = exp_id_q.pop_front();
            check({tag, ".res_valid"}, {31'd0, bus.result_valid_o}, 32'd1);
            check({tag, ".result"}, bus.result_o, e);
            check({tag, ".res_id"}, {29'd0, bus.result_trans_id_o}, {29'd0, eid});
        end else begin
            check({tag, ".res_valid"}, {31'd0, bus.result_valid_o}, 32'd0);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled one falling edge later.
    task automatic apply_vec(input vec_t v, input string tag);
        bus.issue_valid_i     = v.iv;
        bus.issue_op_i        = v.op;
        bus.issue_data_i      = v.data;
        bus.issue_trans_id_i  = v.id;
        bus.commit_valid_i    = v.cv;
        bus.commit_trans_id_i = v.cid;
        bus.flush_i           = v.fl;
        if (v.exp_acc) begin
            exp_q.push_back(v.exp_res);
            exp_id_q.push_back(v.id);
        end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        sb_check(tag);
        check({tag, ".arch"}, bus.acc_arch_o, v.exp_arch);
        check({tag, ".err"}, {31'd0, bus.commit_err_o}, {31'd0, v.exp_err});
        check({tag, ".cnt"}, {{(32-CNT_W){1'b0}}, bus.pending_cnt_o}, {{(32-CNT_W){1'b0}}, v.exp_cnt});
        check({tag, ".ready"}, {31'd0, bus.issue_ready_o}, {31'd0, v.exp_rdy});
`ifdef MAC8_SAT_EN
        check({tag, ".sat"}, {31'd0, bus.sat_o}, {31'd0, v.exp_sat});
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".res_valid"}, {31'd0, bus.result_valid_o}, 32'd0);
        check({tag, ".result"}, bus.result_o, 32'd0);
        check({tag, ".res_id"}, {29'd0, bus.result_trans_id_o}, 32'd0);
        check({tag, ".err"}, {31'd0, bus.commit_err_o}, 32'd0);
        check({tag, ".arch"}, bus.acc_arch_o, 32'd0);
        check({tag, ".cnt"}, {{(32-CNT_W){1'b0}}, bus.pending_cnt_o}, 32'd0);
        check({tag, ".ready"}, {31'd0, bus.issue_ready_o}, 32'd0);
`ifdef MAC8_SAT_EN
        check({tag, ".sat"}, {31'd0, bus.sat_o}, 32'd0);
`endif
    endtask

    // Reference model for one random cycle; returns the vector with its expectations.
    task automatic gen_rand(input logic [2:0] next_id, output vec_t v);
        logic        iv, cv, fl, rdy, acc, ok, nsat;
        mac8_op_e    op;
        logic [31:0] data, nval;
        logic [2:0]  cid;
        longint      s;
        iv   = ($urandom_range(0, 3) != 0);
        op   = ($urandom_range(0, 5) == 0) ? MAC8_INIT : MAC8_ACC;
        data = ($urandom_range(0, 7) == 0) ? $urandom() : (32'($urandom_range(0, 400)) - 32'd200);
        cv   = (m_id.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
        cid  = 3'($urandom_range(0, 7));
        if (m_id.size() > 0 && $urandom_range(0, 9) != 0) cid = m_id[0];
        fl   = ($urandom_range(0, 19) == 0);
        rdy  = (m_id.size() < DEPTH);
        acc  = iv && rdy && !fl;
        ok   = cv && (m_id.size() > 0) && (m_id[0] == cid);
        s    = longint'($signed(m_spec)) + longint'($signed(data));
        nsat = 1'b0;
        nval = s[31:0];
`ifdef MAC8_SAT_EN
        if (s > SMAX) begin nval = 32'h7FFFFFFF; nsat = 1'b1; end
        if (s < SMIN) begin nval = 32'h80000000; nsat = 1'b1; end
`endif
        if (op == MAC8_INIT) begin nval = data; nsat = 1'b0; end
        if (ok) begin
            m_arch = m_val.pop_front();
            m_sat  = m_sat | m_satq.pop_front();
            void'(m_id.pop_front());
        end
        if (fl) begin
            m_id.delete(); m_val.delete(); m_satq.delete();
            m_spec = m_arch;
        end else if (acc) begin
            m_id.push_back(next_id); m_val.push_back(nval); m_satq.push_back(nsat);
            m_spec = nval;
        end
        tbl_sat = m_sat;
        v = mk(iv, op, data, next_id, cv, cid, fl, acc, nval, m_arch, cv && !ok,
               m_id.size(), m_id.size() < DEPTH);
    endtask

    initial begin
        vec_t       v;
        logic [2:0] nid;
        drive_idle();
`ifdef MAC8_SAT_EN
        sat_res = 32'h7FFFFFFF;
`else
        sat_res = 32'h80000010;
`endif
        #12;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // iv op data id | cv cid fl | acc res | arch err cnt rdy
        add(0, MAC8_INIT, 0, 0,              0, 0, 0, 0, 0,            0,            0, 0, 1);
        add(1, MAC8_INIT, 5, 0,              0, 0, 0, 1, 5,            0,            0, 1, 1);
        add(1, MAC8_ACC,  3, 1,              0, 0, 0, 1, 8,            0,            0, 2, 1);
        add(1, MAC8_ACC,  32'hFFFFFFF6, 2,   0, 0, 0, 1, 32'hFFFFFFFE, 0,            0, 3, 1);
        add(0, MAC8_INIT, 0, 0,              1, 0, 0, 0, 0,            5,            0, 2, 1);
        add(0, MAC8_INIT, 0, 0,              1, 1, 0, 0, 0,            8,            0, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 2, 0, 0, 0,            32'hFFFFFFFE, 0, 0, 1);
        // fill the queue, then a commit does not let the full-cycle offer in
        add(1, MAC8_ACC,  1, 3,              0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 1);
        add(1, MAC8_ACC,  1, 4,              0, 0, 0, 1, 0,            32'hFFFFFFFE, 0, 2, 1);
        add(1, MAC8_ACC,  1, 5,              0, 0, 0, 1, 1,            32'hFFFFFFFE, 0, 3, 1);
        add(1, MAC8_ACC,  1, 6,              0, 0, 0, 1, 2,            32'hFFFFFFFE, 0, 4, 0);
        add(1, MAC8_ACC,  1, 7,              1, 3, 0, 0, 0,            32'hFFFFFFFF, 0, 3, 1);
        add(0, MAC8_INIT, 0, 0,              1, 4, 0, 0, 0,            0,            0, 2, 1);
        add(0, MAC8_INIT, 0, 0,              1, 5, 0, 0, 0,            1,            0, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 6, 0, 0, 0,            2,            0, 0, 1);
        // flush restores spec from arch=8
        add(1, MAC8_INIT, 8, 0,              0, 0, 0, 1, 8,            2,            0, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 0, 0, 0, 0,            8,            0, 0, 1);
        add(1, MAC8_ACC,  100, 3,            0, 0, 0, 1, 108,          8,            0, 1, 1);
        add(1, MAC8_ACC,  1, 4,              0, 0, 0, 1, 109,          8,            0, 2, 1);
        add(1, MAC8_ACC,  50, 5,             0, 0, 1, 0, 0,            8,            0, 0, 1);
        add(1, MAC8_ACC,  2, 5,              0, 0, 0, 1, 10,           8,            0, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 5, 0, 0, 0,            10,           0, 0, 1);
        // commit and flush together
        add(1, MAC8_INIT, 8, 0,              0, 0, 0, 1, 8,            10,           0, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 0, 0, 0, 0,            8,            0, 0, 1);
        add(1, MAC8_ACC,  100, 3,            0, 0, 0, 1, 108,          8,            0, 1, 1);
        add(1, MAC8_ACC,  1, 4,              0, 0, 0, 1, 109,          8,            0, 2, 1);
        add(0, MAC8_INIT, 0, 0,              1, 3, 1, 0, 0,            108,          0, 0, 1);
        add(1, MAC8_ACC,  1, 5,              0, 0, 0, 1, 109,          108,          0, 1, 1);
        // bad commits: id mismatch, then empty queue
        add(0, MAC8_INIT, 0, 0,              1, 7, 0, 0, 0,            108,          1, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 5, 0, 0, 0,            109,          0, 0, 1);
        add(0, MAC8_INIT, 0, 0,              1, 2, 0, 0, 0,            109,          1, 0, 1);
        add(0, MAC8_INIT, 0, 0,              0, 0, 0, 0, 0,            109,          0, 0, 1);
        // commit and accept together
        add(1, MAC8_ACC,  1, 6,              0, 0, 0, 1, 110,          109,          0, 1, 1);
        add(1, MAC8_ACC,  1, 7,              1, 6, 0, 1, 111,          110,          0, 1, 1);
        add(0, MAC8_INIT, 0, 0,              1, 7, 0, 0, 0,            111,          0, 0, 1);
        // overflow at the positive limit
        add(1, MAC8_INIT, 32'h7FFFFFF0, 0,   0, 0, 0, 1, 32'h7FFFFFF0, 111,          0, 1, 1);
        add(1, MAC8_ACC,  32'h20, 1,         0, 0, 0, 1, sat_res,      111,          0, 2, 1);
        add(0, MAC8_INIT, 0, 0,              1, 0, 0, 0, 0,            32'h7FFFFFF0, 0, 1, 1);
`ifdef MAC8_SAT_EN
        tbl_sat = 1'b1;
`endif
        add(0, MAC8_INIT, 0, 0,              1, 1, 0, 0, 0,            sat_res,      0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("v%0d", i));

        // async reset with ops pending
        tbl_sat = 1'b0;
        apply_vec(mk(1, MAC8_INIT, 9, 2, 0, 0, 0, 1, 9, sat_res, 0, 1, 1), "pre_rst0");
        apply_vec(mk(1, MAC8_INIT, 4, 3, 0, 0, 0, 1, 4, sat_res, 0, 2, 1), "pre_rst1");
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply_vec(mk(0, MAC8_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "post_rst");

        m_spec = '0; m_arch = '0; m_sat = 1'b0;
        nid = '0;
        for (int i = 0; i < 120; i++) begin
            gen_rand(nid, v);
            if (v.exp_acc) nid = nid + 3'd1;
            apply_vec(v, $sformatf("r%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
